mem_access_stage: RTL and testbench

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

---
 rtl/mem_stage_pkg.sv | 13 +
 rtl/mem_watchdog.sv | 30 +++
 rtl/mem_access_stage.sv | 142 ++++++++++++++
 tb/tb_mem_access_stage.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access pipeline stage: FSM state type and
// the default watchdog limit.
package mem_stage_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t BUSY = 2'd1;
    localparam state_t DONE = 2'd2;

    localparam int unsigned MEM_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/mem_watchdog.sv
// BUSY-cycle counter for the memory stage; flags expiry on the last allowed
// BUSY cycle so the stage can leave BUSY on the following edge.
module mem_watchdog
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = MEM_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic busy,
    output logic expired
);

    localparam int unsigned W = $clog2(TIMEOUT_CYCLES + 1);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (busy) begin
            count <= count + 1'b1;
        end else begin
            count <= '0;
        end
    end

    assign expired = busy && (count == W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: ALU ops pass straight through, loads/stores stall the
// pipe while a registered request handshakes with data memory.
// Optional BUSY watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = MEM_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic        RegWrite_in,
    input  logic        MemtoReg_in,
    input  logic [31:0] ALU_result_in,
    input  logic [31:0] write_data_in,
    input  logic [4:0]  EX_MEM_RegisterRd_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        RegWrite_out,
    output logic        MemtoReg_out,
    output logic [31:0] D_MEM_read_data_out,
    output logic [31:0] D_MEM_read_addr_out,
    output logic [4:0]  EX_MEM_RegisterRd_out,
    output logic        stall_out,
    output logic        mem_error
);

    state_t      state;
    logic        lat_regwrite, lat_memtoreg, lat_we, req_q;
    logic [31:0] lat_addr, lat_wdata, cap_data;
    logic [4:0]  lat_rd;
    logic        mem_op, timeout;

    assign mem_op = valid_in & (MemRead_in | MemWrite_in);

`ifdef MEM_TIMEOUT_EN
    logic err_q;

    mem_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .busy    (state == BUSY),
        .expired (timeout)
    );

    // Raised on the edge that leaves BUSY by timeout, so it lines up with DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= (state == BUSY) & ~dmem_ack & timeout;
        end
    end

    assign mem_error = err_q;
`else
    assign timeout   = 1'b0;
    assign mem_error = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            req_q        <= 1'b0;
            lat_regwrite <= 1'b0;
            lat_memtoreg <= 1'b0;
            lat_we       <= 1'b0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            lat_rd       <= '0;
            cap_data     <= '0;
        end else begin
            case (state)
                IDLE: if (mem_op) begin
                    lat_regwrite <= RegWrite_in;
                    lat_memtoreg <= MemtoReg_in;
                    lat_we       <= MemWrite_in;
                    lat_addr     <= ALU_result_in;
                    lat_wdata    <= write_data_in;
                    lat_rd       <= EX_MEM_RegisterRd_in;
                    req_q        <= 1'b1;
                    state        <= BUSY;
                end
                BUSY: if (dmem_ack) begin
                    cap_data <= lat_we ? '0 : dmem_rdata;
                    req_q    <= 1'b0;
                    state    <= DONE;
                end else if (timeout) begin
                    cap_data <= '0;
                    req_q    <= 1'b0;
                    state    <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign dmem_req   = req_q;
    assign dmem_we    = lat_we;
    assign dmem_addr  = lat_addr;
    assign dmem_wdata = lat_wdata;

    always_comb begin
        RegWrite_out          = 1'b0;
        MemtoReg_out          = 1'b0;
        D_MEM_read_data_out   = '0;
        D_MEM_read_addr_out   = '0;
        EX_MEM_RegisterRd_out = '0;
        stall_out             = 1'b0;
        case (state)
            IDLE: if (valid_in) begin
                RegWrite_out          = RegWrite_in & ~(MemRead_in | MemWrite_in);
                MemtoReg_out          = MemtoReg_in;
                D_MEM_read_addr_out   = ALU_result_in;
                EX_MEM_RegisterRd_out = EX_MEM_RegisterRd_in;
                stall_out             = mem_op;
            end
            BUSY: begin
                MemtoReg_out          = lat_memtoreg;
                D_MEM_read_addr_out   = lat_addr;
                EX_MEM_RegisterRd_out = lat_rd;
                stall_out             = 1'b1;
            end
            DONE: begin
                RegWrite_out          = lat_regwrite & ~mem_error;
                MemtoReg_out          = lat_memtoreg;
                D_MEM_read_data_out   = cap_data;
                D_MEM_read_addr_out   = lat_addr;
                EX_MEM_RegisterRd_out = lat_rd;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: transaction-level model plus directed vectors.
// Timeout scenario runs only when MEM_TIMEOUT_EN is defined.
module tb_mem_access_stage;

    localparam int unsigned TO = 8;

    logic        clk = 1'b0, reset = 1'b0;
    logic        valid_in = 1'b0, MemRead_in = 1'b0, MemWrite_in = 1'b0;
    logic        RegWrite_in = 1'b0, MemtoReg_in = 1'b0;
    logic [31:0] ALU_result_in = '0, write_data_in = '0, dmem_rdata = '0;
    logic [4:0]  EX_MEM_RegisterRd_in = '0;
    logic        dmem_ack = 1'b0;
    logic        dmem_req, dmem_we, RegWrite_out, MemtoReg_out, stall_out, mem_error;
    logic [31:0] dmem_addr, dmem_wdata, D_MEM_read_data_out, D_MEM_read_addr_out;
    logic [4:0]  EX_MEM_RegisterRd_out;

    int checks = 0, errors = 0, stall_cnt = 0, s0 = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in),
        .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
        .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in),
        .ALU_result_in(ALU_result_in), .write_data_in(write_data_in),
        .EX_MEM_RegisterRd_in(EX_MEM_RegisterRd_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .RegWrite_out(RegWrite_out), .MemtoReg_out(MemtoReg_out),
        .D_MEM_read_data_out(D_MEM_read_data_out),
        .D_MEM_read_addr_out(D_MEM_read_addr_out),
        .EX_MEM_RegisterRd_out(EX_MEM_RegisterRd_out),
        .stall_out(stall_out), .mem_error(mem_error)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: one outstanding memory operation, waiting for ack (or the
    // watchdog), then one result cycle.
    typedef struct {
        logic        rw, mtr, we;
        logic [31:0] addr, wdata;
        logic [4:0]  rd;
    } op_t;

    op_t         op;
    bit          m_busy = 0, m_done = 0, m_err = 0;
    int unsigned m_wait = 0;
    logic [31:0] m_data = '0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy <= 0; m_done <= 0; m_err <= 0; m_wait <= 0;
        end else if (m_done) begin
            m_done <= 0; m_err <= 0;
        end else if (m_busy) begin
            m_wait <= m_wait + 1;
            if (dmem_ack) begin
                m_data <= op.we ? 32'h0 : dmem_rdata;
                m_busy <= 0; m_done <= 1;
            end
`ifdef MEM_TIMEOUT_EN
            else if (m_wait + 1 == TO) begin
                m_data <= 32'h0; m_busy <= 0; m_done <= 1; m_err <= 1;
            end
`endif
        end else if (valid_in && (MemRead_in || MemWrite_in)) begin
            op <= '{rw: RegWrite_in, mtr: MemtoReg_in, we: MemWrite_in,
                    addr: ALU_result_in, wdata: write_data_in, rd: EX_MEM_RegisterRd_in};
            m_busy <= 1; m_wait <= 0;
        end
    end

    always begin
        @(negedge clk);
        #3;
        if (stall_out) stall_cnt++;
        check("mem_error", mem_error, m_err);
        if (m_done) begin
            check("done_stall", stall_out, 0);
            check("done_regwrite", RegWrite_out, op.rw & ~m_err);
            check("done_memtoreg", MemtoReg_out, op.mtr);
            check("done_rdata", D_MEM_read_data_out, m_data);
            check("done_addr", D_MEM_read_addr_out, op.addr);
            check("done_rd", EX_MEM_RegisterRd_out, op.rd);
            check("done_req", dmem_req, 0);
        end else if (m_busy) begin
            check("busy_stall", stall_out, 1);
            check("busy_regwrite", RegWrite_out, 0);
            check("busy_req", dmem_req, 1);
            check("busy_we", dmem_we, op.we);
            check("busy_addr", dmem_addr, op.addr);
            check("busy_wdata", dmem_wdata, op.wdata);
        end else begin
            check("idle_req", dmem_req, 0);
            if (valid_in && (MemRead_in || MemWrite_in)) begin
                check("issue_stall", stall_out, 1);
                check("issue_regwrite", RegWrite_out, 0);
            end else if (valid_in) begin
                check("alu_stall", stall_out, 0);
                check("alu_regwrite", RegWrite_out, RegWrite_in);
                check("alu_memtoreg", MemtoReg_out, MemtoReg_in);
                check("alu_addr", D_MEM_read_addr_out, ALU_result_in);
                check("alu_rdata", D_MEM_read_data_out, 0);
                check("alu_rd", EX_MEM_RegisterRd_out, EX_MEM_RegisterRd_in);
            end else begin
                check("bubble_stall", stall_out, 0);
                check("bubble_regwrite", RegWrite_out, 0);
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic r, input logic w, input logic rw,
                         input logic mtr, input logic [31:0] a, input logic [31:0] wd,
                         input logic [4:0] rd);
        valid_in = v; MemRead_in = r; MemWrite_in = w; RegWrite_in = rw;
        MemtoReg_in = mtr; ALU_result_in = a; write_data_in = wd; EX_MEM_RegisterRd_in = rd;
    endtask

    task automatic bubble();
        drive(0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
    endtask

    initial begin
        #2;
        check("rst_req", dmem_req, 0);
        check("rst_we", dmem_we, 0);
        check("rst_err", mem_error, 0);
        check("rst_addr", dmem_addr, 0);
        check("rst_stall", stall_out, 0);
        step(); step();
        reset = 1'b1;

        // ALU op passes through with zero latency
        step(); drive(1, 0, 0, 1, 0, 32'h10, 32'h0, 5'd3); #4;
        check("alu_lit_stall", stall_out, 0);
        check("alu_lit_addr", D_MEM_read_addr_out, 32'h10);
        check("alu_lit_rw", RegWrite_out, 1);
        step(); bubble(); #4;
        check("bubble_lit_rw", RegWrite_out, 0);

        // Load, immediate ack
        step(); drive(1, 1, 0, 1, 1, 32'h100, 32'h0, 5'd5); s0 = stall_cnt;
        step(); dmem_ack = 1; dmem_rdata = 32'hDEADBEEF; #4;
        check("ld_lit_req", dmem_req, 1);
        check("ld_lit_addr", dmem_addr, 32'h100);
        step(); dmem_ack = 0; bubble(); #4;
        check("ld_lit_data", D_MEM_read_data_out, 32'hDEADBEEF);
        check("ld_lit_mtr", MemtoReg_out, 1);
        check("ld_lit_stalls", stall_cnt - s0, 2);

        // Store, ack on 4th BUSY cycle
        step(); drive(1, 0, 1, 0, 0, 32'h200, 32'h55, 5'd7); s0 = stall_cnt;
        step(); #4;
        check("st_lit_we", dmem_we, 1);
        check("st_lit_wdata", dmem_wdata, 32'h55);
        step(); step(); step(); dmem_ack = 1; dmem_rdata = 32'h12345678;
        step(); dmem_ack = 0; bubble(); #4;
        check("st_lit_data", D_MEM_read_data_out, 32'h0);
        check("st_lit_stalls", stall_cnt - s0, 5);

        // Read and write both set: write wins
        step(); drive(1, 1, 1, 1, 0, 32'h300, 32'hA5A5, 5'd2);
        step(); #4;
        check("rw_lit_we", dmem_we, 1);
        dmem_ack = 1; dmem_rdata = 32'h1234;
        step(); dmem_ack = 0; bubble(); #4;
        check("rw_lit_data", D_MEM_read_data_out, 32'h0);

        // Spurious ack in IDLE, then a normal load
        step(); dmem_ack = 1; dmem_rdata = 32'hBAD;
        step(); dmem_ack = 0; #4;
        check("spur_lit_req", dmem_req, 0);
        drive(1, 1, 0, 1, 1, 32'h44, 32'h0, 5'd9);
        step(); dmem_ack = 1; dmem_rdata = 32'hCAFEF00D;
        step(); dmem_ack = 0; bubble(); #4;
        check("spur_lit_data", D_MEM_read_data_out, 32'hCAFEF00D);

        // Reset in the middle of BUSY; late ack ignored
        step(); drive(1, 1, 0, 1, 1, 32'h80, 32'h0, 5'd4);
        step(); #2;
        reset = 1'b0; bubble(); #1;
        check("rst_busy_lit_req", dmem_req, 0);
        step(); step(); reset = 1'b1;
        step(); dmem_ack = 1; dmem_rdata = 32'h1111; #4;
        check("late_ack_lit_req", dmem_req, 0);
        check("late_ack_lit_stall", stall_out, 0);
        step(); dmem_ack = 0; #4;
        check("late_ack_lit_data", D_MEM_read_data_out, 32'h0);

`ifdef MEM_TIMEOUT_EN
        // No ack: watchdog aborts after TO BUSY cycles
        step(); drive(1, 1, 0, 1, 1, 32'h500, 32'h0, 5'd6); s0 = stall_cnt;
        step(); bubble();
        for (int i = 0; i < int'(TO); i++) step();
        #4;
        check("to_lit_err", mem_error, 1);
        check("to_lit_rw", RegWrite_out, 0);
        check("to_lit_data", D_MEM_read_data_out, 32'h0);
        check("to_lit_stalls", stall_cnt - s0, TO + 1);
        step(); #4;
        check("to_lit_err_clear", mem_error, 0);
`else
        step(); #4;
        check("no_to_lit_err", mem_error, 0);
`endif

        step(); step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench did not finish");
    end

endmodule
